// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed and captured at issue, then committed to HI/LO after a fixed latency.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               res_wr_q, res_wr_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] mul_a_s, mul_b_s, mul_p_s;
  logic               div_sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s, quo_s, rem_s;

  // Multiply and divide datapath evaluated on the issuing operands.
  always_comb begin
    if (op == 3'd0) begin
      mul_a_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
      mul_b_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    end else begin
      mul_a_s = {{WIDTH{1'b0}}, src_a};
      mul_b_s = {{WIDTH{1'b0}}, src_b};
    end
    mul_p_s = mul_a_s * mul_b_s;

    // Divide on magnitudes so the most-negative / -1 case wraps to itself instead of trapping.
    div_sgn_s = (op == 3'd2);
    a_neg_s   = div_sgn_s & src_a[WIDTH-1];
    b_neg_s   = div_sgn_s & src_b[WIDTH-1];
    a_mag_s   = a_neg_s ? ({WIDTH{1'b0}} - src_a) : src_a;
    b_mag_s   = b_neg_s ? ({WIDTH{1'b0}} - src_b) : src_b;
    b_safe_s  = (b_mag_s == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag_s;
    q_mag_s   = a_mag_s / b_safe_s;
    r_mag_s   = a_mag_s % b_safe_s;
    quo_s     = (a_neg_s ^ b_neg_s) ? ({WIDTH{1'b0}} - q_mag_s) : q_mag_s;
    rem_s     = a_neg_s ? ({WIDTH{1'b0}} - r_mag_s) : r_mag_s;
  end

  // Next-state logic: issue, countdown and commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_wr_d = res_wr_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_d  = S_RUN;
              cnt_d    = CNT_W'(MULT_CYCLES);
              res_wr_d = 1'b1;
              res_hi_d = mul_p_s[2*WIDTH-1:WIDTH];
              res_lo_d = mul_p_s[WIDTH-1:0];
            end
            3'd2, 3'd3: begin
              state_d  = S_RUN;
              cnt_d    = CNT_W'(DIV_CYCLES);
              res_wr_d = (src_b != {WIDTH{1'b0}});
              res_hi_d = rem_s;
              res_lo_d = quo_s;
            end
            3'd4:    hi_d = src_a;
            3'd5:    lo_d = src_a;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      res_wr_q <= 1'b0;
      res_hi_q <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      res_wr_q <= res_wr_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
